muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 77 +++++++
 tb/tb_muldiv_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result handshake and shared-ALU bus of the sequencer
//   start/op/rs1/rs2/kill  : operation request and pipeline-flush abort
//   busy/done/result       : stall, completion pulse, held result
//   alu_a/alu_b/alu_ctrl   : operands and control to the shared ALU
//   alu_result/alu_carry   : same-cycle ALU response
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;
  modport slave (
    input  start, op, rs1, rs2, kill, alu_result, alu_carry,
    output busy, done, result, alu_a, alu_b, alu_ctrl
  );
  modport master (
    output start, op, rs1, rs2, kill, alu_result, alu_carry,
    input  busy, done, result, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-cycle shift-add multiply / restoring divide on a shared ALU
//   clk, rst (async, active-low) plain ports; everything else on bus (slave modport)
//   a_q is hi/rem, b_q is lo/quo, m_q is mcand/dvsr
module muldiv_sequencer (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run, mul, ok, zdiv;
  logic [31:0] shifted;
  assign run      = state_q == RUN;
  assign mul      = !op_q[1];
  assign shifted  = {a_q[30:0], b_q[31]};
  assign ok       = a_q[31] | bus.alu_carry;
  assign zdiv     = bus.op[1] && bus.rs2 == '0;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = state_q == DONE;
  assign bus.result   = result_q;
  assign bus.alu_a    = run ? (mul ? a_q : shifted) : '0;
  assign bus.alu_b    = (run && (!mul || b_q[0])) ? m_q : '0;
  assign bus.alu_ctrl = {2'b00, run && !mul};
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == IDLE) begin
      if (bus.start && !bus.kill) begin
        op_d    = bus.op;
        a_d     = '0;
        b_d     = bus.op[1] ? bus.rs1 : bus.rs2;
        m_d     = bus.op[1] ? bus.rs2 : bus.rs1;
        cnt_d   = '0;
        state_d = zdiv ? DONE : RUN;
        // divide by zero: quotient all ones, remainder is the dividend
        if (zdiv) result_d = bus.op[0] ? bus.rs1 : '1;
      end
    end else if (state_q == RUN) begin
      // multiply: {carry,sum,lo} >> 1; divide: restoring step with top-bit overflow
      a_d     = mul ? {bus.alu_carry, bus.alu_result[31:1]} : (ok ? bus.alu_result : shifted);
      b_d     = mul ? {bus.alu_result[0], b_q[31:1]} : {b_q[30:0], ok};
      cnt_d   = cnt_q + 5'd1;
      state_d = bus.kill ? IDLE : (cnt_q == 5'd31 ? DONE : RUN);
      // MULHU/REMU take a (hi/rem), MUL/DIVU take b (lo/quo)
      if (!bus.kill && cnt_q == 5'd31) result_d = op_q[0] ? a_d : b_d;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench with a behavioural shared ALU
module tb_muldiv_sequencer;
  logic clk = 0;
  logic rst = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  typedef struct { logic [31:0] res; int t; } exp_t;
  exp_t sb[$];
  muldiv_sequencer_if bus();
  muldiv_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    {bus.alu_carry, bus.alu_result} = (bus.alu_ctrl == 3'b001)
      ? {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1
      : {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", cyc, e.t);
      end
    end
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1;
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
  endtask
  task automatic wait_idle();
    logic ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    issue(o, a, b);
    sb.push_back('{exp, cyc + lat});
    @(negedge clk);
    bus.start = 0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 0;
    bus.op = 0;
    bus.rs1 = 0;
    bus.rs2 = 0;
    bus.kill = 0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
    @(negedge clk);
    rst = 1;
    // MUL 7*6 with a start while busy, plus ALU drive checks
    issue(2'b00, 32'd7, 32'd6);
    sb.push_back('{32'd42, cyc + 33});
    @(negedge clk);
    bus.start = 0;
    check("mul_c1_busy", {31'd0, bus.busy}, 32'd1);
    check("mul_c1_alu_b", bus.alu_b, 32'd0);
    check("mul_c1_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
    @(negedge clk);
    check("mul_c2_alu_b", bus.alu_b, 32'd7);
    repeat (3) @(negedge clk);
    bus.start = 1;
    bus.op = 2'b10;
    bus.rs1 = 32'd5;
    bus.rs2 = 32'd0;
    @(negedge clk);
    bus.start = 0;
    wait_idle();
    check("idle_alu_b", bus.alu_b, 32'd0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 33);
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 33);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op(2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    run_op(2'b11, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 33);
    run_op(2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 1);
    // kill at RUN cycle 10 with a competing start
    issue(2'b00, 32'd9, 32'd9);
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    check("kill_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1;
    bus.start = 1;
    bus.op = 2'b10;
    bus.rs1 = 32'd5;
    bus.rs2 = 32'd0;
    @(negedge clk);
    bus.kill = 0;
    bus.start = 0;
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_result", bus.result, 32'd5);
    repeat (40) @(negedge clk);
    check("kill_no_restart", {31'd0, bus.busy}, 32'd0);
    // kill in DONE still shows the pulse and keeps the result
    issue(2'b00, 32'd3, 32'd5);
    sb.push_back('{32'd15, cyc + 33});
    @(negedge clk);
    bus.start = 0;
    for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
    check("kd_done_seen", {31'd0, bus.done}, 32'd1);
    bus.kill = 1;
    @(negedge clk);
    bus.kill = 0;
    check("kd_busy", {31'd0, bus.busy}, 32'd0);
    check("kd_result", bus.result, 32'd15);
    // asynchronous reset mid-RUN of a divide
    issue(2'b10, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 0;
    check("div_c1_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd1);
    check("div_c1_alu_b", bus.alu_b, 32'd7);
    repeat (4) @(negedge clk);
    #2 rst = 0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_alu_b", bus.alu_b, 32'd0);
    check("arst_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
    @(negedge clk);
    rst = 1;
    run_op(2'b00, 32'd7, 32'd6, 32'd42, 33);
    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
